// File: rtl/replay_pkg.sv
// replay_pkg: shared types and default sizes for the replay buffer.
//   state_e       : IDLE (loading), PLAY (tick-paced replay), DONE (single shot finished)
//   REPLAY_AW     : default buffer address width
//   REPLAY_DW     : default sample width
//   REPLAY_DEPTH  : default buffer depth in words
package replay_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned REPLAY_AW    = 10;
  localparam int unsigned REPLAY_DW    = 16;
  localparam int unsigned REPLAY_DEPTH = 2 ** REPLAY_AW;

endpackage

// File: rtl/replay_ram.sv
// replay_ram: simple dual-port sample store, block-RAM inferable.
//   clk_i      : clock
//   we_i       : write enable (host side)
//   waddr_i    : write address
//   wdata_i    : write data
//   re_i       : read enable; rdata_o updates one cycle later
//   raddr_i    : read address
//   rd_clr_i   : synchronous clear of the read register only (contents kept)
//   rdata_o    : registered read data; holds between reads
module replay_ram #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  input  logic          rd_clr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Output register with sync reset maps onto the block-RAM output latch reset.
  always_ff @(posedge clk_i) begin
    if (rd_clr_i)  rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/replay_buffer.sv
// replay_buffer: host loads up to 2**AW samples, then replays them one per tick.
// Optional build macro REPLAY_LOOP_EN: playback wraps to word 0 forever instead
// of stopping in DONE.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   wr/din: host write strobe and data (accepted in IDLE while not full)
//   go    : start playback (ignored when empty)
//   clr   : abort, empty the buffer, return to IDLE
//   tick  : request next sample in PLAY
//   dout  : replayed sample, holds until the next valid
//   valid : one-cycle strobe, one cycle after the tick
//   busy  : high in PLAY
//   done  : high in DONE
//   count : number of words loaded (0..2**AW)
//
// state | meaning
// IDLE  | loading; wr accepted, go starts playback if count > 0
// PLAY  | each tick reads the next word
// DONE  | last word issued; waits for clr
module replay_buffer
  import replay_pkg::*;
#(
  parameter int AW = REPLAY_AW,
  parameter int DW = REPLAY_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          go,
  input  logic          clr,
  input  logic          tick,
  output logic [DW-1:0] dout,
  output logic          valid,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic          valid_q, valid_d;
  logic          ram_we, ram_re, ram_rd_clr;
  logic          last_rd;

  assign last_rd = ({1'b0, rptr_q} == (count_q - ONE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      rptr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rptr_q  <= rptr_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rptr_d  = rptr_q;
    valid_d = 1'b0;
    ram_we  = 1'b0;
    ram_re  = 1'b0;
    if (clr) begin
      state_d = IDLE;
      count_d = '0;
      rptr_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr && (count_q != DEPTH)) begin
            ram_we  = 1'b1;
            count_d = count_q + ONE;
          end
          if (go && (count_q != '0)) begin
            rptr_d  = '0;
            state_d = PLAY;
          end
        end
        PLAY: begin
          if (tick) begin
            ram_re  = 1'b1;
            valid_d = 1'b1;
            if (last_rd) begin
              rptr_d = '0;
`ifndef REPLAY_LOOP_EN
              state_d = DONE;
`endif
            end else begin
              rptr_d = rptr_q + 1'b1;
            end
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // dout must return to 0 on reset/clr, so the RAM read register is cleared too.
  assign ram_rd_clr = !rst_n || clr;

  replay_ram #(.AW(AW), .DW(DW)) u_ram (
    .clk_i    (clk),
    .we_i     (ram_we),
    .waddr_i  (count_q[AW-1:0]),
    .wdata_i  (din),
    .re_i     (ram_re),
    .raddr_i  (rptr_q),
    .rd_clr_i (ram_rd_clr),
    .rdata_o  (dout)
  );

  assign valid = valid_q;
  assign busy  = (state_q == PLAY);
  assign done  = (state_q == DONE);
  assign count = count_q;

endmodule

// File: tb/tb_replay_buffer.sv
module tb_replay_buffer;
  import replay_pkg::*;

  localparam int AW = REPLAY_AW;
  localparam int DW = REPLAY_DW;
  localparam int N  = REPLAY_DEPTH;

  logic          clk;
  logic          rst_n;
  logic          wr;
  logic [DW-1:0] din;
  logic          go;
  logic          clr;
  logic          tick;
  logic [DW-1:0] dout;
  logic          valid;
  logic          busy;
  logic          done;
  logic [AW:0]   count;

  int n_chk;
  int n_err;

  // reference model: loaded list, playback position, phase (0 load, 1 play, 2 finished)
  logic [DW-1:0] m_mem [N];
  int            m_cnt;
  int            m_pos;
  int            m_phase;
  logic          m_valid;
  logic [DW-1:0] m_dout;
  bit            dead_seen;

  replay_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (wr),
    .din   (din),
    .go    (go),
    .clr   (clr),
    .tick  (tick),
    .dout  (dout),
    .valid (valid),
    .busy  (busy),
    .done  (done),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic w, input logic [DW-1:0] d,
                            input logic g, input logic c, input logic t);
    int old_cnt;
    if (!r || c) begin
      m_phase = 0; m_cnt = 0; m_pos = 0; m_valid = 1'b0; m_dout = '0;
      return;
    end
    m_valid = 1'b0;
    if (m_phase == 0) begin
      old_cnt = m_cnt;
      if (w && m_cnt < N) begin
        m_mem[m_cnt] = d;
        m_cnt++;
      end
      if (g && old_cnt > 0) begin
        m_phase = 1;
        m_pos   = 0;
      end
    end else if (m_phase == 1 && t) begin
      m_dout  = m_mem[m_pos];
      m_valid = 1'b1;
      m_pos++;
      if (m_pos == m_cnt) begin
        m_pos = 0;
`ifndef REPLAY_LOOP_EN
        m_phase = 2;
`endif
      end
    end
  endtask

  // One clock: apply inputs, advance model at the edge, check outputs 1 time unit later.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic g,
                      input logic c, input logic t, input logic r = 1'b1);
    wr = w; din = d; go = g; clr = c; tick = t; rst_n = r;
    @(posedge clk);
    model_edge(r, w, d, g, c, t);
    #1;
    chk("valid", 32'(valid), 32'(m_valid));
    chk("dout",  32'(dout),  32'(m_dout));
    chk("busy",  32'(busy),  32'(m_phase == 1));
    chk("done",  32'(done),  32'(m_phase == 2));
    chk("count", 32'(count), 32'(m_cnt));
    if (valid && dout == 16'hDEAD) dead_seen = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [DW-1:0] v);
    step(1'b1, v, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_chk = 0; n_err = 0; dead_seen = 1'b0;
    m_phase = 0; m_cnt = 0; m_pos = 0; m_valid = 1'b0; m_dout = '0;
    wr = 0; din = '0; go = 0; clr = 0; tick = 0; rst_n = 0;

    // reset
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_count", 32'(count), 32'd0);

    // four words, spaced ticks, extra tick in DONE
    load(16'h1111); load(16'h2222); load(16'h3333); load(16'h4444);
    chk("cnt4", 32'(count), 32'd4);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("spaced_valid", 32'(valid), 32'(i < 4));
      if (i < 4) chk("spaced_dout", 32'(dout), 32'(16'h1111 * (i + 1)));
      idle_cycles(2);
    end
    chk("done4", 32'(done), 32'd1);

    // fill past capacity, continuous replay
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < N + 1; i++) load(16'(i));
    chk("full_count", 32'(count), 32'(N));
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < N + 1; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("full_done", 32'(done), 32'd1);

    // go when empty; write during PLAY
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("empty_go_busy", 32'(busy), 32'd0);
    load(16'h0101); load(16'h0202); load(16'h0303); load(16'h0404);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1);
    end
    chk("no_dead", 32'(dead_seen), 32'd0);

    // clr coincident with a tick mid-playback, then reload one word
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    load(16'h1234); load(16'h5678); load(16'h9ABC); load(16'hDEF0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("clr_tick_valid", 32'(valid), 32'd0);
    chk("clr_count", 32'(count), 32'd0);
    load(16'hABCD);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("reload_dout", 32'(dout), 32'hABCD);

    // reset mid-playback
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    load(16'h0A0A); load(16'h0B0B); load(16'h0C0C);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_dout", 32'(dout), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("rst_tick_valid", 32'(valid), 32'd0);

    // three words, seven continuous ticks (wraps when looping, stops otherwise)
    load(16'h000A); load(16'h000B); load(16'h000C);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
`ifdef REPLAY_LOOP_EN
      chk("loop_dout", 32'(dout), 32'(10 + (i % 3)));
      chk("loop_busy", 32'(busy), 32'd1);
`endif
    end
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // randomized sessions
    for (int s = 0; s < 40; s++) begin
      int n_words;
      n_words = $urandom_range(0, 12);
      for (int i = 0; i < n_words; i++) begin
        if ($urandom_range(0, 3) == 0) idle_cycles(1);
        load(16'($urandom));
      end
      for (int c = 0; c < 30; c++) begin
        step(1'($urandom_range(0, 3) == 0), 16'($urandom),
             1'($urandom_range(0, 5) == 0),
             1'($urandom_range(0, 40) == 0),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 80) != 0));
      end
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
